// File: rtl/seg_p2s_ctrl.sv
// seg_p2s_ctrl
// Parallel-to-serial controller for the seven-segment display chain.
// A DATA_W-bit frame is captured on an accepted start strobe, cleared into the
// external shift-register chain, then shifted out MSB-first on s_clk (HALF
// system-clock cycles per phase). The parallel-output enable s_pen is raised
// once the whole frame has been shifted in.
//
// Ports
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   start   one-cycle request, honoured in IDLE or DONE
//   p_data  frame to send, captured when start is accepted
//   busy    frame in flight
//   done    one-cycle completion pulse
//   s_clk   serial shift clock (chain samples on its rising edge)
//   s_data  serial data, MSB first, changes only while s_clk is low
//   s_clrn  active-low clear to the chain, low during LOAD
//   s_pen   parallel-output enable, high while the displayed frame is valid
module seg_p2s_ctrl #(
    parameter int DATA_W = 64,
    parameter int HALF   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] p_data,
    output logic              busy,
    output logic              done,
    output logic              s_clk,
    output logic              s_data,
    output logic              s_clrn,
    output logic              s_pen
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_t;

    state_t            state, state_d;
    logic [DATA_W-1:0] frame, frame_d, frame_sh;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_d;
    logic [DIV_W-1:0]  div_cnt, div_cnt_d;
    logic              busy_d, done_d, s_clk_d, s_data_d, s_clrn_d, s_pen_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            frame   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s_clk   <= 1'b0;
            s_data  <= 1'b0;
            s_clrn  <= 1'b0;
            s_pen   <= 1'b0;
        end else begin
            state   <= state_d;
            frame   <= frame_d;
            bit_cnt <= bit_cnt_d;
            div_cnt <= div_cnt_d;
            busy    <= busy_d;
            done    <= done_d;
            s_clk   <= s_clk_d;
            s_data  <= s_data_d;
            s_clrn  <= s_clrn_d;
            s_pen   <= s_pen_d;
        end
    end

    always_comb begin
        state_d   = state;
        frame_d   = frame;
        bit_cnt_d = bit_cnt;
        div_cnt_d = div_cnt;
        busy_d    = busy;
        done_d    = 1'b0;
        s_clk_d   = s_clk;
        s_data_d  = s_data;
        s_clrn_d  = s_clrn;
        s_pen_d   = s_pen;
        frame_sh  = frame << 1;

        case (state)
            IDLE, DONE: begin
                state_d  = IDLE;
                s_clrn_d = 1'b1;
                if (start) begin
                    // Outputs registered here are the LOAD-cycle values.
                    state_d   = LOAD;
                    frame_d   = p_data;
                    bit_cnt_d = CNT_FULL;
                    div_cnt_d = '0;
                    busy_d    = 1'b1;
                    s_clrn_d  = 1'b0;
                    s_pen_d   = 1'b0;
                    s_clk_d   = 1'b0;
                    s_data_d  = p_data[DATA_W-1];
                end
            end

            LOAD: begin
                state_d   = SHIFT_LO;
                s_clrn_d  = 1'b1;
                div_cnt_d = '0;
            end

            SHIFT_LO: begin
                if (div_cnt == DIV_LAST) begin
                    state_d   = SHIFT_HI;
                    div_cnt_d = '0;
                    s_clk_d   = 1'b1;
                end else begin
                    div_cnt_d = div_cnt + 1'b1;
                end
            end

            SHIFT_HI: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_d = '0;
                    frame_d   = frame_sh;
                    bit_cnt_d = bit_cnt - 1'b1;
                    s_clk_d   = 1'b0;
                    if (bit_cnt != CNT_ONE) begin
                        state_d  = SHIFT_LO;
                        s_data_d = frame_sh[DATA_W-1];
                    end else begin
                        state_d  = DONE;
                        s_data_d = 1'b0;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        s_pen_d  = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seg_p2s_ctrl.sv
module tb_seg_p2s_ctrl;

    logic        clk;
    logic        rst_n;

    // DUT A: DATA_W=8, HALF=2
    logic        a_start;
    logic [7:0]  a_data;
    logic        a_busy, a_done, a_sclk, a_sdata, a_sclrn, a_pen;

    // DUT B: DATA_W=64, HALF=1
    logic        b_start;
    logic [63:0] b_data;
    logic        b_busy, b_done, b_sclk, b_sdata, b_sclrn, b_pen;

    seg_p2s_ctrl #(.DATA_W(8), .HALF(2)) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (a_start),
        .p_data (a_data),
        .busy   (a_busy),
        .done   (a_done),
        .s_clk  (a_sclk),
        .s_data (a_sdata),
        .s_clrn (a_sclrn),
        .s_pen  (a_pen)
    );

    seg_p2s_ctrl #(.DATA_W(64), .HALF(1)) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (b_start),
        .p_data (b_data),
        .busy   (b_busy),
        .done   (b_done),
        .s_clk  (b_sclk),
        .s_data (b_sdata),
        .s_clrn (b_sclrn),
        .s_pen  (b_pen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] word;
        int unsigned bits;
        int unsigned dcyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int unsigned c);
        while (cyc < c) tick();
    endtask

    // Monitor A: assemble bits on s_clk rises, score on done
    logic [63:0] a_sh;
    int unsigned a_n;
    logic        a_pclk, a_pdone;
    exp_t        a_e;
    initial begin
        a_sh = '0; a_n = 0; a_pclk = 1'b0; a_pdone = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                a_sh = '0; a_n = 0; a_pclk = 1'b0; a_pdone = 1'b0;
            end else begin
                if (a_sclk && !a_pclk) begin
                    a_sh = {a_sh[62:0], a_sdata};
                    a_n++;
                end
                if (a_pdone) check("a_done_width", {63'd0, a_done}, 64'd0);
                if (a_done) begin
                    if (qa.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL a_unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
                    end else begin
                        a_e = qa.pop_front();
                        check("a_word", a_sh, a_e.word);
                        check("a_bits", 64'(a_n), 64'(a_e.bits));
                        check("a_done_cycle", 64'(cyc), 64'(a_e.dcyc));
                        check("a_pen_at_done", {63'd0, a_pen}, 64'd1);
                        check("a_busy_at_done", {63'd0, a_busy}, 64'd0);
                    end
                    a_sh = '0;
                    a_n  = 0;
                end
                a_pclk  = a_sclk;
                a_pdone = a_done;
            end
        end
    end

    // Monitor B
    logic [63:0] b_sh;
    int unsigned b_n;
    logic        b_pclk, b_pdone;
    exp_t        b_e;
    initial begin
        b_sh = '0; b_n = 0; b_pclk = 1'b0; b_pdone = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                b_sh = '0; b_n = 0; b_pclk = 1'b0; b_pdone = 1'b0;
            end else begin
                if (b_sclk && !b_pclk) begin
                    b_sh = {b_sh[62:0], b_sdata};
                    b_n++;
                end
                if (b_pdone) check("b_done_width", {63'd0, b_done}, 64'd0);
                if (b_done) begin
                    if (qb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL b_unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
                    end else begin
                        b_e = qb.pop_front();
                        check("b_word", b_sh, b_e.word);
                        check("b_bits", 64'(b_n), 64'(b_e.bits));
                        check("b_done_cycle", 64'(cyc), 64'(b_e.dcyc));
                        check("b_pen_at_done", {63'd0, b_pen}, 64'd1);
                        check("b_busy_at_done", {63'd0, b_busy}, 64'd0);
                    end
                    b_sh = '0;
                    b_n  = 0;
                end
                b_pclk  = b_sclk;
                b_pdone = b_done;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int unsigned e0, e1, e2, e3, e4;

    initial begin
        a_start = 1'b0; a_data = '0;
        b_start = 1'b0; b_data = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy",  {63'd0, a_busy},  64'd0);
        check("rst_done",  {63'd0, a_done},  64'd0);
        check("rst_sclk",  {63'd0, a_sclk},  64'd0);
        check("rst_sdata", {63'd0, a_sdata}, 64'd0);
        check("rst_sclrn", {63'd0, a_sclrn}, 64'd0);
        check("rst_pen",   {63'd0, a_pen},   64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("clrn_before_edge", {63'd0, a_sclrn}, 64'd0);
        tick();
        check("a_clrn_after_rel", {63'd0, a_sclrn}, 64'd1);
        check("b_clrn_after_rel", {63'd0, b_sclrn}, 64'd1);

        // Frame A5 with an ignored start at E0+10
        e0 = cyc + 1;
        a_start = 1'b1;
        a_data  = 8'hA5;
        qa.push_back('{word: 64'hA5, bits: 8, dcyc: e0 + 33});
        tick();
        a_start = 1'b0;
        check("load_busy",  {63'd0, a_busy},  64'd1);
        check("load_clrn",  {63'd0, a_sclrn}, 64'd0);
        check("load_pen",   {63'd0, a_pen},   64'd0);
        check("load_sdata", {63'd0, a_sdata}, 64'd1);
        check("load_sclk",  {63'd0, a_sclk},  64'd0);
        tick();
        check("clrn_after_load", {63'd0, a_sclrn}, 64'd1);
        wait_to(e0 + 2);
        check("sclk_before_rise", {63'd0, a_sclk}, 64'd0);
        wait_to(e0 + 3);
        check("sclk_first_rise", {63'd0, a_sclk}, 64'd1);
        wait_to(e0 + 9);
        a_start = 1'b1;
        a_data  = 8'hFF;
        tick();
        a_start = 1'b0;
        check("busy_ignored_start", {63'd0, a_busy}, 64'd1);
        wait_to(e0 + 32);
        check("pen_before_done", {63'd0, a_pen}, 64'd0);

        // Back-to-back: start 3C during DONE
        wait_to(e0 + 33);
        check("done_cycle_direct", {63'd0, a_done}, 64'd1);
        e1 = e0 + 34;
        a_start = 1'b1;
        a_data  = 8'h3C;
        qa.push_back('{word: 64'h3C, bits: 8, dcyc: e1 + 33});
        tick();
        a_start = 1'b0;
        check("b2b_pen_low", {63'd0, a_pen},  64'd0);
        check("b2b_busy",    {63'd0, a_busy}, 64'd1);
        check("b2b_sdata",   {63'd0, a_sdata}, 64'd0);
        while (cyc < e1 + 33) begin
            a_data = 8'($urandom);
            tick();
        end
        wait_to(e1 + 36);
        check("pen_held_idle",  {63'd0, a_pen},  64'd1);
        check("busy_idle",      {63'd0, a_busy}, 64'd0);

        // Reset mid-frame
        e2 = cyc + 1;
        a_start = 1'b1;
        a_data  = 8'h5A;
        tick();
        a_start = 1'b0;
        wait_to(e2 + 12);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  {63'd0, a_busy},  64'd0);
        check("mid_rst_done",  {63'd0, a_done},  64'd0);
        check("mid_rst_sclk",  {63'd0, a_sclk},  64'd0);
        check("mid_rst_sdata", {63'd0, a_sdata}, 64'd0);
        check("mid_rst_sclrn", {63'd0, a_sclrn}, 64'd0);
        check("mid_rst_pen",   {63'd0, a_pen},   64'd0);
        wait_to(e2 + 15);
        rst_n = 1'b1;
        #1;
        check("rel_clrn_low", {63'd0, a_sclrn}, 64'd0);
        tick();
        check("rel_clrn_high", {63'd0, a_sclrn}, 64'd1);
        check("rel_pen_low",   {63'd0, a_pen},   64'd0);
        check("rel_busy_low",  {63'd0, a_busy},  64'd0);
        repeat (30) tick();
        check("no_done_after_abort_pen", {63'd0, a_pen}, 64'd0);

        e3 = cyc + 1;
        a_start = 1'b1;
        a_data  = 8'h96;
        qa.push_back('{word: 64'h96, bits: 8, dcyc: e3 + 33});
        tick();
        a_start = 1'b0;
        wait_to(e3 + 36);
        check("post_rst_pen", {63'd0, a_pen}, 64'd1);

        // HALF=1, 64-bit frame, p_data scrambled after capture
        e4 = cyc + 1;
        b_start = 1'b1;
        b_data  = 64'h0123_4567_89AB_CDEF;
        qb.push_back('{word: 64'h0123_4567_89AB_CDEF, bits: 64, dcyc: e4 + 129});
        tick();
        b_start = 1'b0;
        check("b_busy_load", {63'd0, b_busy}, 64'd1);
        while (cyc < e4 + 129) begin
            b_data = {$urandom, $urandom};
            tick();
        end
        wait_to(e4 + 132);
        check("b_pen_idle", {63'd0, b_pen}, 64'd1);

        check("a_queue_empty", 64'(qa.size()), 64'd0);
        check("b_queue_empty", 64'(qb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
